// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared constants and source-select encoding for the register-file writeback controller.
package rf_writeback_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Origin of the value currently sitting in the registered write slot.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_writeback_ctrl_wb_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count; holds long-op results awaiting writeback.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO may still accept a write in the cycle its head leaves.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage has no reset; entries are only ever read behind the
  // reset-cleared count, so clearing the array would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port driver: arbitrates ALU and long-op results and tracks
// outstanding long-op destinations in a busy scoreboard for decode hazard stalls.
module rf_writeback_ctrl #(
  parameter int XLEN     = rf_writeback_ctrl_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      alu_valid,
  input  logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                           alu_data,
  input  logic                                      lq_valid,
  output logic                                      lq_ready,
  input  logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] lq_rd,
  input  logic [XLEN-1:0]                           lq_data,
  input  logic                                      issue_valid,
  input  logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] issue_rd,
  output logic                                      issue_ready,
  input  logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] rs2,
  output logic                                      rs1_busy,
  output logic                                      rs2_busy,
  output logic [rf_writeback_ctrl_pkg::REG_ADDR_W-1:0] WriteRegister,
  output logic [XLEN-1:0]                           WriteData,
  output logic                                      RegWrite
);

  import rf_writeback_ctrl_pkg::*;

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int LQ_CW   = $clog2(LQ_DEPTH) + 1;

  logic [ENTRY_W-1:0]    lq_head;
  logic [REG_ADDR_W-1:0] lq_head_rd;
  logic [XLEN-1:0]       lq_head_data;
  logic                  lq_full;
  logic                  lq_empty;
  logic [LQ_CW-1:0]      lq_count;
  logic                  lq_push;
  logic                  lq_pop;

  wb_src_e               src_d, src_q;
  logic [REG_ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [XLEN-1:0]       wr_data_d, wr_data_q;

  logic [NUM_REGS-1:0]   busy_d, busy_q;
  logic                  busy_set;
  logic                  busy_clr;

  // Long-op result queue; writes to x0 are accepted but never stored.
  assign lq_ready = !lq_full;
  assign lq_push  = lq_valid && lq_ready && (lq_rd != '0);

  wb_sync_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_lq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lq_push),
    .wdata_i ({lq_rd, lq_data}),
    .pop_i   (lq_pop),
    .rdata_o (lq_head),
    .full_o  (lq_full),
    .empty_o (lq_empty),
    .count_o (lq_count)
  );

  assign {lq_head_rd, lq_head_data} = lq_head;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src_d     = SRC_NONE;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_valid && (alu_rd != '0)) begin
      src_d     = SRC_ALU;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (!lq_empty) begin
      src_d     = SRC_LQ;
      wr_addr_d = lq_head_rd;
      wr_data_d = lq_head_data;
    end
  end

  assign lq_pop = (src_d == SRC_LQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= SRC_NONE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      src_q     <= src_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign RegWrite      = (src_q != SRC_NONE);
  assign WriteRegister = wr_addr_q;
  assign WriteData     = wr_data_q;

  // Scoreboard: cleared on the same edge the register file captures a long-op result.
  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
  assign busy_set    = issue_valid && (issue_rd != '0) && issue_ready;
  assign busy_clr    = (src_q == SRC_LQ);

  always_comb begin
    busy_d = busy_q;
    if (busy_clr) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    // Applied after the clear so a same-edge issue to the same rd stays busy.
    if (busy_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = (rs1 != '0) && busy_q[rs1];
  assign rs2_busy = (rs2 != '0) && busy_q[rs2];

  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_valid && (alu_rd != '0) && busy_q[alu_rd]));

  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    RegWrite |-> (WriteRegister != '0));

  a_lq_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    lq_count <= LQ_CW'(LQ_DEPTH));

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: queue/scoreboard reference model plus literal spot checks.
module tb_rf_writeback_ctrl;

  localparam int XLEN     = 32;
  localparam int LQ_DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            lq_valid = 1'b0;
  logic            lq_ready;
  logic [4:0]      lq_rd = '0;
  logic [XLEN-1:0] lq_data = '0;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = '0;
  logic            issue_ready;
  logic [4:0]      rs1 = '0;
  logic [4:0]      rs2 = '0;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      WriteRegister;
  logic [XLEN-1:0] WriteData;
  logic            RegWrite;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_writeback_ctrl #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lq_valid      (lq_valid),
    .lq_ready      (lq_ready),
    .lq_rd         (lq_rd),
    .lq_data       (lq_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending results and a busy flag per register.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  ent_t            m_e;
  bit              m_busy[32];
  bit              m_rw = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  bit              m_from_lq = 1'b0;
  bit              m_ready_pre;
  bit              m_issue_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_rw = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_from_lq = 1'b0;
    end else begin
      m_ready_pre = (m_q.size() < LQ_DEPTH);
      m_issue_ok  = issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
      if (m_rw && m_from_lq) m_busy[m_addr] = 1'b0;
      if (alu_valid && alu_rd != 0) begin
        m_rw = 1'b1; m_addr = alu_rd; m_data = alu_data; m_from_lq = 1'b0;
      end else if (m_q.size() > 0) begin
        m_e = m_q.pop_front();
        m_rw = 1'b1; m_addr = m_e.rd; m_data = m_e.data; m_from_lq = 1'b1;
      end else begin
        m_rw = 1'b0; m_from_lq = 1'b0;
      end
      if (lq_valid && m_ready_pre && lq_rd != 0) m_q.push_back('{lq_rd, lq_data});
      if (m_issue_ok && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("m_regwrite", 32'(RegWrite), 32'(m_rw));
    check("m_wreg", 32'(WriteRegister), 32'(m_addr));
    check("m_wdata", WriteData, m_data);
    check("m_lq_ready", 32'(lq_ready), 32'(m_q.size() < LQ_DEPTH));
    check("m_rs1_busy", 32'(rs1_busy), 32'(rs1 != 0 && m_busy[rs1]));
    check("m_rs2_busy", 32'(rs2_busy), 32'(rs2 != 0 && m_busy[rs2]));
    check("m_issue_ready", 32'(issue_ready), 32'(issue_rd == 0 || !m_busy[issue_rd]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with an ALU result offered.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_wreg", 32'(WriteRegister), 32'd0);
      check("rst_wdata", WriteData, 32'd0);
      check("rst_lq_ready", 32'(lq_ready), 32'd1);
      tick();
    end
    rst_n = 1'b1;
    mid();
    check("rel_regwrite_pre", 32'(RegWrite), 32'd0);
    tick();
    alu_valid = 1'b0;
    mid();
    check("rel_regwrite", 32'(RegWrite), 32'd1);
    check("rel_wreg", 32'(WriteRegister), 32'd5);
    check("rel_wdata", WriteData, 32'hDEADBEEF);
    tick();

    // Writes to x0 from both sources are dropped.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00000BAD;
    lq_valid = 1'b1; lq_rd = 5'd0; lq_data = 32'h0000BAD0;
    mid();
    check("x0_lq_ready", 32'(lq_ready), 32'd1);
    tick();
    alu_valid = 1'b0; lq_valid = 1'b0;
    mid();
    check("x0_regwrite_a", 32'(RegWrite), 32'd0);
    check("x0_hold_wdata", WriteData, 32'hDEADBEEF);
    tick();
    mid();
    check("x0_regwrite_b", 32'(RegWrite), 32'd0);
    check("x0_lq_ready_b", 32'(lq_ready), 32'd1);
    tick();

    // Scoreboard round trip on rd 7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    mid();
    check("sb_issue_ready_pre", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0; rs1 = 5'd7;
    lq_valid = 1'b1; lq_rd = 5'd7; lq_data = 32'h00001234;
    mid();
    check("sb_rs1_busy", 32'(rs1_busy), 32'd1);
    check("sb_issue_ready", 32'(issue_ready), 32'd0);
    tick();
    lq_valid = 1'b0;
    mid();
    check("sb_regwrite_n1", 32'(RegWrite), 32'd0);
    tick();
    mid();
    check("sb_regwrite_n2", 32'(RegWrite), 32'd1);
    check("sb_wreg", 32'(WriteRegister), 32'd7);
    check("sb_wdata", WriteData, 32'h00001234);
    check("sb_rs1_busy_n2", 32'(rs1_busy), 32'd1);
    tick();
    mid();
    check("sb_rs1_free", 32'(rs1_busy), 32'd0);
    check("sb_issue_ready_post", 32'(issue_ready), 32'd1);
    tick();

    // ALU priority over a queued long-op result.
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0; rs1 = 5'd3;
    lq_valid = 1'b1; lq_rd = 5'd3; lq_data = 32'h00000033;
    tick();
    lq_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h00000044;
    mid();
    check("pri_idle", 32'(RegWrite), 32'd0);
    tick();
    alu_rd = 5'd5; alu_data = 32'h00000055;
    mid();
    check("pri_w4", 32'(WriteRegister), 32'd4);
    tick();
    alu_rd = 5'd6; alu_data = 32'h00000066;
    mid();
    check("pri_w5", 32'(WriteRegister), 32'd5);
    tick();
    alu_valid = 1'b0;
    mid();
    check("pri_w6", 32'(WriteRegister), 32'd6);
    check("pri_busy3_a", 32'(rs1_busy), 32'd1);
    tick();
    mid();
    check("pri_w3", 32'(WriteRegister), 32'd3);
    check("pri_d3", WriteData, 32'h00000033);
    check("pri_busy3_b", 32'(rs1_busy), 32'd1);
    tick();
    mid();
    check("pri_busy3_clr", 32'(rs1_busy), 32'd0);
    check("pri_done", 32'(RegWrite), 32'd0);
    tick();

    // Fill the queue while the ALU hogs the port, then drain.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h000000A0;
    lq_valid = 1'b1; lq_rd = 5'd11; lq_data = 32'h000000B1;
    mid();
    check("full_ready0", 32'(lq_ready), 32'd1);
    tick();
    alu_data = 32'h000000A1; lq_rd = 5'd12; lq_data = 32'h000000B2;
    mid();
    check("full_ready1", 32'(lq_ready), 32'd1);
    tick();
    alu_data = 32'h000000A2; lq_rd = 5'd13; lq_data = 32'h000000B3;
    mid();
    check("full_ready_full", 32'(lq_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    mid();
    check("full_still_full", 32'(lq_ready), 32'd0);
    check("full_last_alu", WriteData, 32'h000000A2);
    tick();
    mid();
    check("drain_ready", 32'(lq_ready), 32'd1);
    check("drain_w11", 32'(WriteRegister), 32'd11);
    check("drain_d11", WriteData, 32'h000000B1);
    tick();
    lq_valid = 1'b0;
    mid();
    check("drain_w12", 32'(WriteRegister), 32'd12);
    tick();
    mid();
    check("drain_w13", 32'(WriteRegister), 32'd13);
    check("drain_d13", WriteData, 32'h000000B3);
    tick();
    mid();
    check("drain_empty", 32'(RegWrite), 32'd0);
    tick();

    // Issue to rd 9 on the edge its queued write clears busy[9].
    lq_valid = 1'b1; lq_rd = 5'd9; lq_data = 32'h00000099;
    tick();
    lq_valid = 1'b0;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    mid();
    check("same_w9", 32'(WriteRegister), 32'd9);
    check("same_rw", 32'(RegWrite), 32'd1);
    check("same_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0; rs2 = 5'd9; rs1 = 5'd0;
    mid();
    check("same_busy9", 32'(rs2_busy), 32'd1);
    check("same_rs1_x0", 32'(rs1_busy), 32'd0);
    tick();

    // Reset in the middle of outstanding work.
    issue_valid = 1'b1; issue_rd = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'h000000CC;
    lq_valid = 1'b1; lq_rd = 5'd21; lq_data = 32'h000000DD;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0; lq_valid = 1'b0; rs1 = 5'd20;
    mid();
    check("mid_busy20", 32'(rs1_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rw", 32'(RegWrite), 32'd0);
    check("mid_rst_busy", 32'(rs1_busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("mid_no_write", 32'(RegWrite), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
